// File: rtl/ysyx_lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, access sizes,
// AXI response codes and the alignment rule used by both request check and datapath.
package ysyx_lsu_pkg;

   localparam int XLEN = 32;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RADDR = 3'd1,
      S_RDATA = 3'd2,
      S_WADDR = 3'd3,
      S_WRESP = 3'd4,
      S_RESP  = 3'd5
   } lsu_state_e;

   // func3[1:0] is the access size, func3[2] selects zero extension on loads
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a_lo);
      case (f3[1:0])
         SZ_B:    return 1'b0;
         SZ_H:    return a_lo[0];
         default: return (a_lo != 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/ysyx_lsu_align.sv
// Byte-lane steering: store data replication and strobes, load extract and extend,
// plus the misalignment flag for an incoming request.
module ysyx_lsu_align
   import ysyx_lsu_pkg::*;
(
   input  logic [2:0]      func3,
   input  logic [1:0]      addr_lo,
   input  logic [XLEN-1:0] st_data,
   input  logic [XLEN-1:0] ld_raw,
   input  logic [2:0]      req_func3,
   input  logic [1:0]      req_addr_lo,
   output logic [3:0]      wstrb,
   output logic [XLEN-1:0] wdata,
   output logic [XLEN-1:0] ld_data,
   output logic            req_misalign
);

   logic [XLEN-1:0] ld_shift;

   always_comb begin
      ld_shift = ld_raw >> {addr_lo, 3'b000};
      wstrb    = 4'b1111;
      wdata    = st_data;
      ld_data  = ld_shift;
      case (func3[1:0])
         SZ_B: begin
            wstrb   = 4'b0001 << addr_lo;
            wdata   = {4{st_data[7:0]}};
            ld_data = func3[2] ? {24'b0, ld_shift[7:0]} : {{24{ld_shift[7]}}, ld_shift[7:0]};
         end
         SZ_H: begin
            wstrb   = 4'b0011 << addr_lo;
            wdata   = {2{st_data[15:0]}};
            ld_data = func3[2] ? {16'b0, ld_shift[15:0]} : {{16{ld_shift[15]}}, ld_shift[15:0]};
         end
         default: begin
            wstrb   = 4'b1111;
            wdata   = st_data;
            ld_data = ld_shift;
         end
      endcase
   end

   assign req_misalign = is_misaligned(req_func3, req_addr_lo);

endmodule

// File: rtl/ysyx_lsu.sv
// Load/store unit: one outstanding load or store issued as an AXI4-Lite master,
// result or completion returned to execute as a single-cycle pulse.
module ysyx_lsu
   import ysyx_lsu_pkg::*;
#(
   parameter int BIT_W = XLEN
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             exu_avalid,
   input  logic             exu_ren,
   input  logic             exu_wen,
   input  logic [2:0]       exu_func3,
   input  logic [BIT_W-1:0] exu_addr,
   input  logic [BIT_W-1:0] exu_wdata,
   output logic [BIT_W-1:0] exu_rdata,
   output logic             exu_rvalid,
   output logic             exu_wready,
   output logic             exu_fault,
   output logic [BIT_W-1:0] araddr,
   output logic             arvalid,
   input  logic             arready,
   input  logic [BIT_W-1:0] rdata,
   input  logic [1:0]       rresp,
   input  logic             rvalid,
   output logic             rready,
   output logic [BIT_W-1:0] awaddr,
   output logic             awvalid,
   input  logic             awready,
   output logic [BIT_W-1:0] wdata,
   output logic [3:0]       wstrb,
   output logic             wvalid,
   input  logic             wready,
   input  logic [1:0]       bresp,
   input  logic             bvalid,
   output logic             bready
);

   lsu_state_e       state_q, state_d;
   logic [BIT_W-1:0] addr_q, addr_d;
   logic [BIT_W-1:0] wdata_q, wdata_d;
   logic [BIT_W-1:0] rdata_q, rdata_d;
   logic [2:0]       func3_q, func3_d;
   logic             is_load_q, is_load_d;
   logic             fault_q, fault_d;
   logic             aw_done_q, aw_done_d;
   logic             w_done_q, w_done_d;

   logic [BIT_W-1:0] ld_data;
   logic             req_misalign;
   logic             aw_fire, w_fire;

   ysyx_lsu_align u_align (
      .func3       (func3_q),
      .addr_lo     (addr_q[1:0]),
      .st_data     (wdata_q),
      .ld_raw      (rdata),
      .req_func3   (exu_func3),
      .req_addr_lo (exu_addr[1:0]),
      .wstrb       (wstrb),
      .wdata       (wdata),
      .ld_data     (ld_data),
      .req_misalign(req_misalign)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         func3_q   <= '0;
         is_load_q <= 1'b0;
         fault_q   <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         func3_q   <= func3_d;
         is_load_q <= is_load_d;
         fault_q   <= fault_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

   assign aw_fire = awvalid && awready;
   assign w_fire  = wvalid && wready;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      func3_d   = func3_q;
      is_load_d = is_load_q;
      fault_d   = fault_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      case (state_q)
         S_IDLE: begin
            if (exu_avalid && (exu_ren || exu_wen)) begin
               addr_d    = exu_addr;
               func3_d   = exu_func3;
               is_load_d = exu_ren;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               if (exu_wen) wdata_d = exu_wdata;
               // misaligned requests never touch the bus
               if (req_misalign) begin
                  fault_d = 1'b1;
                  state_d = S_RESP;
               end else begin
                  fault_d = 1'b0;
                  state_d = exu_ren ? S_RADDR : S_WADDR;
               end
            end
         end
         S_RADDR: if (arready) state_d = S_RDATA;
         S_RDATA: begin
            if (rvalid) begin
               rdata_d = ld_data;
               fault_d = (rresp != RESP_OKAY);
               state_d = S_RESP;
            end
         end
         S_WADDR: begin
            aw_done_d = aw_done_q || aw_fire;
            w_done_d  = w_done_q || w_fire;
            if (aw_done_d && w_done_d) state_d = S_WRESP;
         end
         S_WRESP: begin
            if (bvalid) begin
               fault_d = (bresp != RESP_OKAY);
               state_d = S_RESP;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      arvalid    = (state_q == S_RADDR);
      rready     = (state_q == S_RDATA);
      awvalid    = (state_q == S_WADDR) && !aw_done_q;
      wvalid     = (state_q == S_WADDR) && !w_done_q;
      bready     = (state_q == S_WRESP);
      exu_rvalid = (state_q == S_RESP) && is_load_q;
      exu_wready = (state_q == S_RESP) && !is_load_q;
      araddr     = {addr_q[BIT_W-1:2], 2'b00};
      awaddr     = {addr_q[BIT_W-1:2], 2'b00};
      exu_rdata  = rdata_q;
      exu_fault  = fault_q;
   end

endmodule

// File: tb/tb_ysyx_lsu.sv
// Directed bench for ysyx_lsu: loads, stores, misalignment, bus errors and reset abort,
// with a small AXI slave driven from each stimulus task.
module tb_ysyx_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        exu_avalid, exu_ren, exu_wen;
   logic [2:0]  exu_func3;
   logic [31:0] exu_addr, exu_wdata, exu_rdata;
   logic        exu_rvalid, exu_wready, exu_fault;
   logic [31:0] araddr, rdata, awaddr, wdata;
   logic        arvalid, arready, rvalid, rready;
   logic [1:0]  rresp, bresp;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic [3:0]  wstrb;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ysyx_lsu dut (
      .clk(clk), .rst(rst),
      .exu_avalid(exu_avalid), .exu_ren(exu_ren), .exu_wen(exu_wen),
      .exu_func3(exu_func3), .exu_addr(exu_addr), .exu_wdata(exu_wdata),
      .exu_rdata(exu_rdata), .exu_rvalid(exu_rvalid), .exu_wready(exu_wready),
      .exu_fault(exu_fault),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   // Issue one load against an always-ready slave; observe for a fixed 12-cycle window.
   task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd,
                          input logic [1:0] rr, output logic [31:0] data, output logic flt,
                          output int lat, output int ar_n, output int rv_n,
                          output logic [31:0] ar_seen);
      data = '0; flt = 1'b0; lat = 0; ar_n = 0; rv_n = 0; ar_seen = '0;
      arready = 1'b1; rvalid = 1'b1; rdata = rd; rresp = rr;
      exu_avalid = 1'b1; exu_ren = 1'b1; exu_wen = 1'b0;
      exu_func3 = f3; exu_addr = a; exu_wdata = '0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (arvalid) begin ar_n++; ar_seen = araddr; end
         if (exu_rvalid) begin
            rv_n++;
            if (lat == 0) begin lat = c; data = exu_rdata; flt = exu_fault; end
            exu_avalid = 1'b0; exu_ren = 1'b0;
         end
      end
      arready = 1'b0; rvalid = 1'b0;
   endtask

   // Issue one store; awready rises aw_dly cycles after the W handshake (0 = always ready).
   task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                           input logic [1:0] br, input int aw_dly,
                           output logic [3:0] strb_seen, output logic [31:0] wd_seen,
                           output logic [31:0] aw_seen, output int lat, output int aw_n,
                           output int w_n, output int wr_n, output logic flt);
      int w_hs;
      strb_seen = '0; wd_seen = '0; aw_seen = '0; lat = 0; aw_n = 0; w_n = 0; wr_n = 0;
      flt = 1'b0; w_hs = 0;
      wready = 1'b1; bvalid = 1'b1; bresp = br; awready = (aw_dly == 0);
      exu_avalid = 1'b1; exu_ren = 1'b0; exu_wen = 1'b1;
      exu_func3 = f3; exu_addr = a; exu_wdata = wd;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (wvalid && wready) begin
            w_n++; strb_seen = wstrb; wd_seen = wdata;
            if (w_hs == 0) w_hs = c;
         end
         awready = (aw_dly == 0) || (w_hs != 0 && c >= w_hs + aw_dly);
         if (awvalid && awready) begin aw_n++; aw_seen = awaddr; end
         if (exu_wready) begin
            wr_n++;
            if (lat == 0) begin lat = c; flt = exu_fault; end
            exu_avalid = 1'b0; exu_wen = 1'b0;
         end
      end
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      exu_avalid = 1'b0; exu_ren = 1'b0; exu_wen = 1'b0; exu_func3 = '0;
      exu_addr = '0; exu_wdata = '0;
      arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({arvalid, rready, awvalid, wvalid, bready} !== 5'b0)
         begin errors++; $display("FAIL reset_axi got %b want 00000", {arvalid, rready, awvalid, wvalid, bready}); end
      checks++;
      if ({exu_rvalid, exu_wready, exu_fault} !== 3'b0)
         begin errors++; $display("FAIL reset_exu got %b want 000", {exu_rvalid, exu_wready, exu_fault}); end
      checks++;
      if (exu_rdata !== 32'h0)
         begin errors++; $display("FAIL reset_rdata got %h want 00000000", exu_rdata); end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_lw();
      logic [31:0] d, ar; logic f; int lat, ar_n, rv_n;
      do_load(3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 2'b00, d, f, lat, ar_n, rv_n, ar);
      checks++;
      if (ar !== 32'h8000_0004) begin errors++; $display("FAIL lw_araddr got %h want 80000004", ar); end
      checks++;
      if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_data got %h want deadbeef", d); end
      checks++;
      if (f !== 1'b0) begin errors++; $display("FAIL lw_fault got %b want 0", f); end
      checks++;
      if (lat != 3) begin errors++; $display("FAIL lw_latency got %0d want 3", lat); end
      checks++;
      if (ar_n != 1 || rv_n != 1)
         begin errors++; $display("FAIL lw_single got ar=%0d rv=%0d want 1 1", ar_n, rv_n); end
   endtask

   task automatic test_lb_lbu();
      logic [31:0] d, ar; logic f; int lat, ar_n, rv_n;
      do_load(3'b000, 32'h8000_0003, 32'h80FF_FF00, 2'b00, d, f, lat, ar_n, rv_n, ar);
      checks++;
      if (d !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data got %h want ffffff80", d); end
      checks++;
      if (ar !== 32'h8000_0000) begin errors++; $display("FAIL lb_araddr got %h want 80000000", ar); end
      do_load(3'b100, 32'h8000_0003, 32'h80FF_FF00, 2'b00, d, f, lat, ar_n, rv_n, ar);
      checks++;
      if (d !== 32'h0000_0080) begin errors++; $display("FAIL lbu_data got %h want 00000080", d); end
      do_load(3'b001, 32'h8000_0002, 32'h8001_7FFF, 2'b00, d, f, lat, ar_n, rv_n, ar);
      checks++;
      if (d !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_data got %h want ffff8001", d); end
      do_load(3'b101, 32'h8000_0002, 32'h8001_7FFF, 2'b00, d, f, lat, ar_n, rv_n, ar);
      checks++;
      if (d !== 32'h0000_8001) begin errors++; $display("FAIL lhu_data got %h want 00008001", d); end
   endtask

   task automatic test_misaligned_load();
      logic [31:0] d, ar; logic f; int lat, ar_n, rv_n;
      do_load(3'b001, 32'h8000_0001, 32'h1111_1111, 2'b00, d, f, lat, ar_n, rv_n, ar);
      checks++;
      if (ar_n != 0) begin errors++; $display("FAIL mis_lh_arvalid got %0d want 0", ar_n); end
      checks++;
      if (lat != 1) begin errors++; $display("FAIL mis_lh_latency got %0d want 1", lat); end
      checks++;
      if (f !== 1'b1) begin errors++; $display("FAIL mis_lh_fault got %b want 1", f); end
      checks++;
      if (rv_n != 1) begin errors++; $display("FAIL mis_lh_rvalid_count got %0d want 1", rv_n); end
   endtask

   task automatic test_sh_delayed_aw();
      logic [3:0] s; logic [31:0] wd, aw; int lat, aw_n, w_n, wr_n; logic f;
      do_store(3'b001, 32'h8000_0002, 32'h0000_1234, 2'b00, 2, s, wd, aw, lat, aw_n, w_n, wr_n, f);
      checks++;
      if (s !== 4'b1100) begin errors++; $display("FAIL sh_wstrb got %b want 1100", s); end
      checks++;
      if (wd !== 32'h1234_1234) begin errors++; $display("FAIL sh_wdata got %h want 12341234", wd); end
      checks++;
      if (aw !== 32'h8000_0000) begin errors++; $display("FAIL sh_awaddr got %h want 80000000", aw); end
      checks++;
      if (lat != 5) begin errors++; $display("FAIL sh_latency got %0d want 5", lat); end
      checks++;
      if (aw_n != 1 || w_n != 1 || wr_n != 1)
         begin errors++; $display("FAIL sh_single got aw=%0d w=%0d wr=%0d want 1 1 1", aw_n, w_n, wr_n); end
      checks++;
      if (f !== 1'b0) begin errors++; $display("FAIL sh_fault got %b want 0", f); end
   endtask

   task automatic test_sw_bresp_err();
      logic [3:0] s; logic [31:0] wd, aw; int lat, aw_n, w_n, wr_n; logic f;
      do_store(3'b010, 32'h8000_0008, 32'hCAFE_F00D, 2'b10, 0, s, wd, aw, lat, aw_n, w_n, wr_n, f);
      checks++;
      if (f !== 1'b1) begin errors++; $display("FAIL sw_fault got %b want 1", f); end
      checks++;
      if (s !== 4'b1111 || wd !== 32'hCAFE_F00D)
         begin errors++; $display("FAIL sw_lanes got %b %h want 1111 cafef00d", s, wd); end
      checks++;
      if (lat != 3) begin errors++; $display("FAIL sw_latency got %0d want 3", lat); end
   endtask

   task automatic test_sb();
      logic [3:0] s; logic [31:0] wd, aw; int lat, aw_n, w_n, wr_n; logic f;
      do_store(3'b000, 32'h8000_0001, 32'h0000_00AB, 2'b00, 0, s, wd, aw, lat, aw_n, w_n, wr_n, f);
      checks++;
      if (s !== 4'b0010) begin errors++; $display("FAIL sb_wstrb got %b want 0010", s); end
      checks++;
      if (wd !== 32'hABAB_ABAB) begin errors++; $display("FAIL sb_wdata got %h want abababab", wd); end
      checks++;
      if (f !== 1'b0) begin errors++; $display("FAIL sb_fault got %b want 0", f); end
      do_store(3'b010, 32'h8000_0006, 32'h5555_5555, 2'b00, 0, s, wd, aw, lat, aw_n, w_n, wr_n, f);
      checks++;
      if (aw_n != 0 || w_n != 0 || f !== 1'b1 || lat != 1)
         begin errors++; $display("FAIL mis_sw got aw=%0d w=%0d f=%b lat=%0d want 0 0 1 1", aw_n, w_n, f, lat); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d, ar; logic f; int lat, ar_n, rv_n;
      arready = 1'b1; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
      exu_avalid = 1'b1; exu_ren = 1'b1; exu_wen = 1'b0;
      exu_func3 = 3'b010; exu_addr = 32'h8000_0020; exu_wdata = '0;
      @(negedge clk);
      exu_avalid = 1'b0; exu_ren = 1'b0;
      @(negedge clk);
      checks++;
      if (rready !== 1'b1) begin errors++; $display("FAIL mid_rready_before got %b want 1", rready); end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (rready !== 1'b0 || arvalid !== 1'b0)
         begin errors++; $display("FAIL mid_rready_after got %b%b want 00", rready, arvalid); end
      arready = 1'b0;
      @(negedge clk);
      checks++;
      if (exu_rdata !== 32'h0) begin errors++; $display("FAIL mid_rdata_cleared got %h want 00000000", exu_rdata); end
      rst = 1'b1;
      @(negedge clk);
      do_load(3'b010, 32'h8000_0010, 32'h1234_5678, 2'b00, d, f, lat, ar_n, rv_n, ar);
      checks++;
      if (d !== 32'h1234_5678 || lat != 3 || ar_n != 1 || ar !== 32'h8000_0010)
         begin errors++; $display("FAIL mid_clean_load got d=%h lat=%0d ar=%0d addr=%h want 12345678 3 1 80000010", d, lat, ar_n, ar); end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_lb_lbu();
      test_misaligned_load();
      test_sh_delayed_aw();
      test_sw_bresp_err();
      test_sb();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
